rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port controller for the 32 x DATA_WIDTH register file in the pipelined RISC-V core. It sequences a post-reset zero-fill of x1..x31, since the register file has no reset. It then shares the single write port between the pipeline writeback stage and a multi-cycle unit (divider or load-miss path). It also keeps a pending-write scoreboard that decode uses to stall on operands still owed by the multi-cycle unit.

## Interface
- DATA_WIDTH, 32, register width
- STARVE_LIMIT, 4, cycles mc may wait before it forces a writeback hold (1..15)

- clk  in  1  clock; the arbiter's state updates on posedge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  writeback stage requests a write
- wb_addr  in  5  writeback destination
- wb_data  in  DATA_WIDTH  writeback data
- wb_hold  out  1  pipeline must hold the writeback stage (wb_* stable) and upstream this cycle
- mc_valid  in  1  multi-cycle unit has a result
- mc_addr  in  5  its destination
- mc_data  in  DATA_WIDTH  its data
- mc_ready  out  1  mc result accepted this cycle
- sb_set  in  1  a multi-cycle op issued this cycle
- sb_addr  in  5  destination of that op
- rs1_addr, rs2_addr  in  5 each  decode operand queries
- pend_rs1, pend_rs2  out  1 each  operand awaits an mc write
- rf_wr_en  out  1  to register file wr_en
- rf_wr_addr  out  5  to register file wr_addr
- rf_wr_data  out  DATA_WIDTH  to register file wr_data
- init_done  out  1  zero-fill complete

## Operation
- FSM, two states:
  - CLEAR is the reset state. clr_addr starts at 1.
  - CLEAR sequencing: rf_wr_en=1, rf_wr_addr=clr_addr, rf_wr_data=0, clr_addr++ each cycle.
  - After the cycle with clr_addr=31, go to RUN.
  - In CLEAR: wb_hold=1, mc_ready=0, init_done=0.
  - RUN: init_done=1, arbitration below. RUN is held until reset.
- Requests:
  - wb request = wb_valid && wb_addr!=0.
  - mc request = mc_valid; mc_addr=0 is accepted but not written.
- RUN arbitration, evaluated in order:
  - wait_cnt==STARVE_LIMIT && mc_valid: grant mc, wb_hold=1.
  - Else, a wb request: grant wb, mc_ready=0, wb_hold=0.
  - Else, mc_valid: grant mc, wb_hold=0.
  - Else: rf_wr_en=0.
- Grant outputs:
  - Grant wb: rf_wr_en=1, wr_addr/data = wb_*.
  - Grant mc: mc_ready=1, rf_wr_en=(mc_addr!=0), wr_addr/data = mc_*.
- wait_cnt, 4 bits:
  - Cleared to 0 when mc_valid=0 or mc_ready=1.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Scoreboard:
  - 32-bit pend, bit 0 always 0.
  - On an mc grant with mc_addr!=0, clear pend[mc_addr].
  - On sb_set with sb_addr!=0, set pend[sb_addr]. Set wins over a same-cycle clear of the same address.
  - pend_rsN = pend[rsN_addr], combinational on the registered bits.
  - A same-cycle clear is not forwarded: pend_rsN stays 1 in the grant cycle. Decode receives the data via writeback forwarding on the next cycle.
- Reset, including reset during CLEAR or RUN:
  - Outputs and state: state=CLEAR, clr_addr=1, wait_cnt=0, pend=0.
  - Fill restarts from x1; a partial fill is never resumed.

## Timing
- All outputs are combinational from inputs and registered state, with zero added latency. The register file samples them on its own write edge within the same cycle.
- Output values in the first cycle after reset:
  - Zero-fill write port: rf_wr_en=1, rf_wr_addr=1, rf_wr_data=0.
  - Handshake and status: wb_hold=1, mc_ready=0, init_done=0.
  - Scoreboard: pend_rs1=pend_rs2=0.
- CLEAR lasts exactly 31 cycles. The first RUN cycle is the 32nd cycle after reset deasserts.
- An mc request stalled by back-to-back wb writes is granted no later than STARVE_LIMIT+1 cycles after mc_valid rises.
- The wb requester must keep wb_* stable while wb_hold=1. It is granted the cycle after the forced mc grant, unless a new starvation hold occurs, which is impossible because wait_cnt restarts at 0.
- mc must keep mc_* stable until mc_ready.

## Structure
- Shared core package holds:
  - REG_COUNT=32, REG_ADDR_W=5.
  - The FSM state enum {CLEAR, RUN}.
  - The default STARVE_LIMIT constant.
- One natural sub-module: rf_scoreboard, holding the pend register, set/clear logic and the two query ports. Arbitration and the FSM stay in the top.

## Test plan
- Zero-fill:
  - Stimulus: reset 2 cycles, release.
  - Response: 31 writes with addr 1..31 and data 0 in consecutive cycles; init_done rises on cycle 32; wb_hold=1 throughout CLEAR.
- Priority:
  - Stimulus: in RUN, wb_valid with x5=0xA5A5A5A5 and mc_valid with x7=0x1234, same cycle.
  - Response: x5 written, mc_ready=0.
  - Follow-up: next cycle with wb_valid=0, x7 written, mc_ready=1.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: wb writes x3 every cycle while mc_valid holds x9.
  - Response: mc is granted on the 5th cycle with wb_hold=1; the held wb write to x3 lands the following cycle.
- Scoreboard:
  - Stimulus: sb_set x12, then query rs1=12.
  - Response: pend_rs1=1 until the mc write to x12 is granted; 0 the cycle after.
  - Stimulus: sb_set x12 in the same cycle as the mc grant to x12.
  - Response: bit stays 1.
- x0 handling:
  - Stimulus: wb_valid to x0 while mc_valid to x4.
  - Response: mc is granted the same cycle.
  - Stimulus: mc to x0.
  - Response: mc_ready=1, rf_wr_en=0.
  - Stimulus: sb_set to x0.
  - Response: pend_rs1 for rs1=0 stays 0.
- Reset mid-operation:
  - Stimulus: assert reset at clr_addr=17; separately, assert reset in RUN with pend[6]=1.
  - Response: the fill restarts at x1; pend clears to 0.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-port controller.
package rf_wb_arbiter_pkg;

    localparam int unsigned REG_COUNT            = 32;
    localparam int unsigned REG_ADDR_W           = 5;
    localparam int unsigned WAIT_CNT_W           = 4;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register that is still
// owed a result by the multi-cycle unit; x0 can never be pending.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic                  o_pend_rs1,
    output logic                  o_pend_rs2
);

    logic [REG_COUNT-1:0] r_pend;
    logic [REG_COUNT-1:0] w_pend_nxt;

    // Set is applied after clear so a re-issued op keeps its bit.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_clr_en && (i_clr_addr != '0)) begin
            w_pend_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set_en && (i_set_addr != '0)) begin
            w_pend_nxt[i_set_addr] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Queries read registered state only; a same-cycle clear is not forwarded.
    assign o_pend_rs1 = r_pend[i_rs1_addr];
    assign o_pend_rs2 = r_pend[i_rs2_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: post-reset zero-fill of x1..x31, then
// arbitration between writeback and a multi-cycle unit with starvation guard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_hold,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_addr,
    input  logic [DATA_WIDTH-1:0] mc_data,
    output logic                  mc_ready,
    input  logic                  sb_set,
    input  logic [REG_ADDR_W-1:0] sb_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  pend_rs1,
    output logic                  pend_rs2,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  init_done
);

    localparam logic [REG_ADDR_W-1:0] LAST_ADDR = REG_ADDR_W'(REG_COUNT - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = WAIT_CNT_W'(STARVE_LIMIT);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [REG_ADDR_W-1:0] r_clr_addr;
    logic [REG_ADDR_W-1:0] w_clr_addr_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_nxt;
    logic                  w_wb_req;
    logic                  w_starve;
    logic                  w_mc_grant;

    assign w_wb_req = wb_valid && (wb_addr != '0);
    assign w_starve = mc_valid && (r_wait_cnt == WAIT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CLEAR;
            r_clr_addr <= REG_ADDR_W'(1);
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Next state and write-port / handshake outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_mc_grant     = 1'b0;
        rf_wr_en       = 1'b0;
        rf_wr_addr     = '0;
        rf_wr_data     = '0;
        wb_hold        = 1'b0;
        mc_ready       = 1'b0;
        init_done      = 1'b0;

        case (r_state)
            CLEAR: begin
                rf_wr_en       = 1'b1;
                rf_wr_addr     = r_clr_addr;
                wb_hold        = 1'b1;
                w_clr_addr_nxt = r_clr_addr + REG_ADDR_W'(1);
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                init_done = 1'b1;
                if (w_starve) begin
                    w_mc_grant = 1'b1;
                    wb_hold    = 1'b1;
                end else if (w_wb_req) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = wb_addr;
                    rf_wr_data = wb_data;
                end else if (mc_valid) begin
                    w_mc_grant = 1'b1;
                end
                if (w_mc_grant) begin
                    mc_ready   = 1'b1;
                    rf_wr_en   = (mc_addr != '0);
                    rf_wr_addr = mc_addr;
                    rf_wr_data = mc_data;
                end
            end
        endcase
    end

    // Cycles an mc result has waited without acceptance, saturating.
    always_comb begin
        if (!mc_valid || mc_ready) begin
            w_wait_nxt = '0;
        end else if (r_wait_cnt < WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + WAIT_CNT_W'(1);
        end else begin
            w_wait_nxt = r_wait_cnt;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .i_clr_en   (w_mc_grant),
        .i_clr_addr (mc_addr),
        .i_set_en   (sb_set),
        .i_set_addr (sb_addr),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_pend_rs1 (pend_rs1),
        .o_pend_rs2 (pend_rs2)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the write-port rules.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned FILL  = 31;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_hold;
    logic          mc_valid;
    logic [4:0]    mc_addr;
    logic [DW-1:0] mc_data;
    logic          mc_ready;
    logic          sb_set;
    logic [4:0]    sb_addr;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic          pend_rs1;
    logic          pend_rs2;
    logic          rf_wr_en;
    logic [4:0]    rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic          init_done;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_hold    (wb_hold),
        .mc_valid   (mc_valid),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .pend_rs1   (pend_rs1),
        .pend_rs2   (pend_rs2),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // Observation vector {en, addr, data, hold, ready, done, p1, p2};
    // address/data are don't-care while no write is issued.
    function automatic logic [42:0] obs();
        logic [42:0] v;
        v = {rf_wr_en, rf_wr_addr, rf_wr_data, wb_hold, mc_ready, init_done, pend_rs1, pend_rs2};
        if (rf_wr_en !== 1'b1) v[41:5] = '0;
        return v;
    endfunction

    function automatic logic [42:0] ev(input logic en, input logic [4:0] a, input logic [DW-1:0] d,
                                       input logic h, input logic r, input logic dn,
                                       input logic p1, input logic p2);
        return en ? {en, a, d, h, r, dn, p1, p2} : {1'b0, 5'd0, 32'd0, h, r, dn, p1, p2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
        sb_set   = 1'b0; sb_addr = '0;
        rs1_addr = '0;   rs2_addr = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle_inputs();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [42:0] e;
        do_reset(2);
        @(negedge clk);
        e = ev(1'b1, 5'd1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_first_cycle: got %h expected %h", obs(), e);
        end
        tick();
    endtask

    task automatic test_zero_fill();
        logic [42:0] e;
        do_reset(2);
        for (int i = 0; i < int'(FILL); i++) begin
            @(negedge clk);
            e = ev(1'b1, 5'(i + 1), '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL zero_fill_%0d: got %h expected %h", i, obs(), e);
            end
            tick();
        end
        @(negedge clk);
        e = ev(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL zero_fill_done: got %h expected %h", obs(), e);
        end
        tick();
    endtask

    task automatic test_priority();
        logic [42:0] e;
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5A5_A5A5;
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h0000_1234;
        @(negedge clk);
        e = ev(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL priority_wb: got %h expected %h", obs(), e);
        end
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        e = ev(1'b1, 5'd7, 32'h0000_1234, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL priority_mc_next: got %h expected %h", obs(), e);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [42:0] e;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_0003;
        mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h0000_0999;
        for (int i = 0; i < int'(LIMIT); i++) begin
            @(negedge clk);
            e = ev(1'b1, 5'd3, 32'hDEAD_0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL starve_wb_%0d: got %h expected %h", i, obs(), e);
            end
            tick();
        end
        @(negedge clk);
        e = ev(1'b1, 5'd9, 32'h0000_0999, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL starve_mc_forced: got %h expected %h", obs(), e);
        end
        tick();
        mc_valid = 1'b0;
        @(negedge clk);
        e = ev(1'b1, 5'd3, 32'hDEAD_0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL starve_wb_lands: got %h expected %h", obs(), e);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        logic [42:0] e;
        rs1_addr = 5'd12; rs2_addr = 5'd12;
        sb_set = 1'b1; sb_addr = 5'd12;
        @(negedge clk);
        e = ev(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL sb_set_cycle: got %h expected %h", obs(), e);
        end
        tick();
        sb_set = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = ev(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL sb_pending_%0d: got %h expected %h", i, obs(), e);
            end
            tick();
        end
        mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'h0000_C0DE;
        @(negedge clk);
        e = ev(1'b1, 5'd12, 32'h0000_C0DE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL sb_grant_not_forwarded: got %h expected %h", obs(), e);
        end
        tick();
        mc_valid = 1'b0;
        @(negedge clk);
        e = ev(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL sb_cleared: got %h expected %h", obs(), e);
        end
        tick();
        sb_set = 1'b1; sb_addr = 5'd12;
        tick();
        mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'h0000_0BAD;
        @(negedge clk);
        e = ev(1'b1, 5'd12, 32'h0000_0BAD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL sb_set_and_clear_grant: got %h expected %h", obs(), e);
        end
        tick();
        mc_valid = 1'b0; sb_set = 1'b0;
        @(negedge clk);
        e = ev(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL sb_set_wins: got %h expected %h", obs(), e);
        end
        tick();
        mc_valid = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_x0();
        logic [42:0] e;
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        mc_valid = 1'b1; mc_addr = 5'd4; mc_data = 32'h0000_0044;
        @(negedge clk);
        e = ev(1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL x0_wb_yields: got %h expected %h", obs(), e);
        end
        tick();
        wb_valid = 1'b0;
        mc_addr = 5'd0; mc_data = 32'h0000_0055;
        @(negedge clk);
        e = ev(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL x0_mc_no_write: got %h expected %h", obs(), e);
        end
        tick();
        mc_valid = 1'b0;
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        sb_set = 1'b0;
        @(negedge clk);
        e = ev(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL x0_never_pending: got %h expected %h", obs(), e);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [42:0] e;
        do_reset(1);
        repeat (16) tick();
        @(negedge clk);
        e = ev(1'b1, 5'd17, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL mid_fill_addr17: got %h expected %h", obs(), e);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        e = ev(1'b1, 5'd1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL mid_fill_restart: got %h expected %h", obs(), e);
        end
        tick();
        @(negedge clk);
        e = ev(1'b1, 5'd2, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL mid_fill_continue: got %h expected %h", obs(), e);
        end
        tick();
        repeat (int'(FILL) - 2) tick();
        rs1_addr = 5'd6;
        sb_set = 1'b1; sb_addr = 5'd6;
        tick();
        sb_set = 1'b0;
        @(negedge clk);
        e = ev(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL run_pend6_set: got %h expected %h", obs(), e);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        e = ev(1'b1, 5'd1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL run_reset_clears: got %h expected %h", obs(), e);
        end
        tick();
        idle_inputs();
    endtask

    // Randomized traffic against a model phrased in terms of cycles since
    // reset, how long the mc result has waited, and a per-register pending map.
    task automatic test_random();
        bit          pend[32];
        int          mcq[$];
        int          cyc;
        int          waited;
        int          age;
        bit          starve;
        bit          wbreq;
        bit          g_mc;
        bit          granted;
        logic [42:0] e;
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        waited = 0;
        age = 0;
        cyc = 0;
        do_reset(1);
        for (int n = 0; n < 500; n++) begin
            if (wb_hold !== 1'b1 || cyc < int'(FILL)) begin
                wb_valid = ($urandom_range(0, 99) < 60);
                wb_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wb_data  = $urandom;
            end
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            sb_set = 1'b0;
            if (cyc >= int'(FILL)) begin
                if (!mc_valid && mcq.size() > 0 && $urandom_range(0, 2) == 0) begin
                    mc_valid = 1'b1;
                    mc_addr  = 5'(mcq[0]);
                    mc_data  = $urandom;
                    age = 0;
                end
                if ($urandom_range(0, 4) == 0 && mcq.size() < 4) begin
                    sb_set  = 1'b1;
                    sb_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    mcq.push_back(int'(sb_addr));
                end
            end

            g_mc = 1'b0;
            if (cyc < int'(FILL)) begin
                e = ev(1'b1, 5'(cyc + 1), '0, 1'b1, 1'b0, 1'b0, pend[rs1_addr], pend[rs2_addr]);
            end else begin
                starve = mc_valid && (waited >= int'(LIMIT));
                wbreq  = wb_valid && (wb_addr != 5'd0);
                g_mc   = starve || (!wbreq && mc_valid);
                if (g_mc)
                    e = ev(mc_addr != 5'd0, mc_addr, mc_data, starve, 1'b1, 1'b1, pend[rs1_addr], pend[rs2_addr]);
                else if (wbreq)
                    e = ev(1'b1, wb_addr, wb_data, 1'b0, 1'b0, 1'b1, pend[rs1_addr], pend[rs2_addr]);
                else
                    e = ev(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, pend[rs1_addr], pend[rs2_addr]);
            end

            @(negedge clk);
            n_tests++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h expected %h", n, obs(), e);
            end
            granted = (mc_ready === 1'b1) && mc_valid;
            if (granted) begin
                n_tests++;
                if (age > int'(LIMIT)) begin
                    n_fail++;
                    $display("FAIL random_mc_latency: got %0d cycles expected <= %0d", age + 1, LIMIT + 1);
                end
            end

            if (g_mc && mc_addr != 5'd0) pend[mc_addr] = 1'b0;
            if (sb_set && sb_addr != 5'd0) pend[sb_addr] = 1'b1;
            if (!mc_valid || g_mc) waited = 0;
            else if (waited < int'(LIMIT)) waited++;

            tick();
            cyc++;
            if (mc_valid) age++;
            if (granted) begin
                mc_valid = 1'b0;
                void'(mcq.pop_front());
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_fill();
        test_priority();
        test_starvation();
        test_scoreboard();
        test_x0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
